// File: rtl/afu_base_pkg.sv
// afu_base -- shared types and constants for the AFU write path.
//   t_cci_clAddr / t_cci_clData : CCI cache-line address and data.
//   t_arb_state                 : write_arbiter drain FSM (RUN/DRAIN/DONE).
//   WR_SKID_DEPTH               : per-requester skid FIFO depth.
//   WR_STALL_THRESH             : FIFO occupancy at which a requester is stalled.
package afu_base;
  localparam int CCI_CLADDR_W = 42;
  localparam int CCI_CLDATA_W = 512;

  typedef logic [CCI_CLADDR_W-1:0] t_cci_clAddr;
  typedef logic [CCI_CLDATA_W-1:0] t_cci_clData;

  localparam int WR_SKID_DEPTH   = 4;
  localparam int WR_STALL_THRESH = 2;
  localparam int WR_OCC_W        = $clog2(WR_SKID_DEPTH) + 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } t_arb_state;

  typedef struct packed {
    t_cci_clAddr addr;
    t_cci_clData data;
  } t_wr_req;
endpackage

// File: rtl/write_skid_fifo.sv
// write_skid_fifo -- per-requester skid buffer for line writes.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (empties FIFO)
//   i_push            : write i_addr/i_data this cycle
//   i_pop             : drop the head entry this cycle (caller guarantees non-empty)
//   i_addr, i_data    : incoming line address/data
//   o_addr, o_data    : head entry (valid while o_occ != 0)
//   o_occ             : current occupancy, 0..WR_SKID_DEPTH
module write_skid_fifo
  import afu_base::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [CCI_CLADDR_W-1:0] i_addr,
  input  logic [CCI_CLDATA_W-1:0] i_data,
  output logic [CCI_CLADDR_W-1:0] o_addr,
  output logic [CCI_CLDATA_W-1:0] o_data,
  output logic [WR_OCC_W-1:0]     o_occ
);
  localparam int PW = $clog2(WR_SKID_DEPTH);

  t_wr_req         r_mem [WR_SKID_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [WR_OCC_W-1:0] r_occ;
  logic            w_full, w_push;

  assign w_full = (r_occ == WR_OCC_W'(WR_SKID_DEPTH));
  // The stall threshold keeps the FIFO from ever filling past depth; the
  // guard only protects the pointers if a requester ignores backpressure.
  assign w_push = i_push && (!w_full || i_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, i_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage needs no reset: pointers/occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{addr: i_addr, data: i_data};
  end

  assign o_addr = r_mem[r_rd_ptr].addr;
  assign o_data = r_mem[r_rd_ptr].data;
  assign o_occ  = r_occ;
endmodule

// File: rtl/write_arbiter.sv
// write_arbiter -- merges N_REQ write streams onto one CCI write channel with
// per-requester skid FIFOs, round-robin grant, write-credit tracking and a
// drain (quiesce) handshake.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/addr/data : per-requester write request (pushed unconditionally)
//   req_stall         : per-requester backpressure (2-cycle reaction latency)
//   c1_almost_full    : CCI write channel almost full, blocks issue
//   wr_valid/addr/data: registered merged write request
//   wr_rsp_valid      : one write completion
//   drain_req/done    : quiesce request / quiesced
//   outstanding       : writes issued and not yet completed
//   err_underflow     : sticky, completion seen with nothing outstanding
//   stat_issued       : per-requester issue counters
// Optional feature: define WRITE_ARBITER_STATS_EN to build the per-requester
// 32-bit issue counters; otherwise stat_issued is tied to zero.
module write_arbiter
  import afu_base::*;
#(
  parameter int N_REQ           = 4,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N_REQ-1:0]                     req_valid,
  input  logic [N_REQ-1:0][CCI_CLADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0][CCI_CLDATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]                     req_stall,
  input  logic                                 c1_almost_full,
  output logic                                 wr_valid,
  output logic [CCI_CLADDR_W-1:0]              wr_addr,
  output logic [CCI_CLDATA_W-1:0]              wr_data,
  input  logic                                 wr_rsp_valid,
  input  logic                                 drain_req,
  output logic                                 drain_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 err_underflow,
  output logic [N_REQ-1:0][31:0]               stat_issued
);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int RR_W  = $clog2(N_REQ);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  t_arb_state                         r_state, w_state_nxt;
  logic [RR_W-1:0]                    r_rr_ptr;
  logic [1:0]                         r_drain_age;
  logic                               w_drain_stall;
  logic [N_REQ-1:0]                   w_pop, w_nonempty;
  logic [N_REQ-1:0][CCI_CLADDR_W-1:0] w_head_addr;
  logic [N_REQ-1:0][CCI_CLDATA_W-1:0] w_head_data;
  logic [N_REQ-1:0][WR_OCC_W-1:0]     w_occ;
  logic                               w_grant_vld, w_issue;
  logic [RR_W-1:0]                    w_grant_idx;
  logic [RR_W:0]                      w_idx;

  for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
    write_skid_fifo u_fifo (
      .clk    (clk),
      .reset  (reset),
      .i_push (req_valid[g]),
      .i_pop  (w_pop[g]),
      .i_addr (req_addr[g]),
      .i_data (req_data[g]),
      .o_addr (w_head_addr[g]),
      .o_data (w_head_data[g]),
      .o_occ  (w_occ[g])
    );
    assign w_nonempty[g] = (w_occ[g] != '0);
    // Stalling at 2 leaves room for the two valids already in flight.
    assign req_stall[g]  = w_drain_stall ||
                           (w_occ[g] >= WR_OCC_W'(WR_STALL_THRESH));
  end

  // Round-robin: first non-empty FIFO at or after r_rr_ptr.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (RR_W+1)'(k);
      if (w_idx >= (RR_W+1)'(N_REQ)) w_idx = w_idx - (RR_W+1)'(N_REQ);
      if (!w_grant_vld && w_nonempty[w_idx[RR_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_idx[RR_W-1:0];
      end
    end
  end

  assign w_issue = w_grant_vld && !c1_almost_full && (outstanding < MAX_OUT);

  always_comb begin
    w_pop = '0;
    if (w_issue) w_pop[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_valid <= w_issue;
      if (w_issue) begin
        wr_addr  <= w_head_addr[w_grant_idx];
        wr_data  <= w_head_data[w_grant_idx];
        r_rr_ptr <= (w_grant_idx == RR_W'(N_REQ-1)) ? '0 : w_grant_idx + 1'b1;
      end
    end
  end

  // Credits: issue and completion in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      case ({w_issue, wr_rsp_valid})
        2'b10: outstanding <= outstanding + 1'b1;
        2'b01: begin
          if (outstanding == '0) err_underflow <= 1'b1;
          else                   outstanding   <= outstanding - 1'b1;
        end
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Drain FSM. r_drain_age delays DONE until two cycles after the stall
  // went up, so valids already in flight from requesters land and issue first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_drain_age <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state != DRAIN)       r_drain_age <= '0;
      else if (r_drain_age != 2'd2) r_drain_age <= r_drain_age + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_drain_stall = 1'b0;
    drain_done    = 1'b0;
    case (r_state)
      RUN: if (drain_req) w_state_nxt = DRAIN;
      DRAIN: begin
        w_drain_stall = 1'b1;
        if (r_drain_age == 2'd2 && !(|w_nonempty) && !(|req_valid) &&
            outstanding == '0 && !wr_valid)
          w_state_nxt = DONE;
      end
      DONE: begin
        // Stay quiesced until the drain request is withdrawn.
        w_drain_stall = 1'b1;
        drain_done    = 1'b1;
        if (!drain_req) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

`ifdef WRITE_ARBITER_STATS_EN
  logic [N_REQ-1:0][31:0] r_stat;
  always_ff @(posedge clk) begin
    if (reset)        r_stat <= '0;
    else if (w_issue) r_stat[w_grant_idx] <= r_stat[w_grant_idx] + 32'd1;
  end
  assign stat_issued = r_stat;
`else
  assign stat_issued = '0;
`endif
endmodule

// File: tb/tb_write_arbiter.sv
module tb_write_arbiter;
  import afu_base::*;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]                   req_valid;
  logic [N-1:0][CCI_CLADDR_W-1:0] req_addr;
  logic [N-1:0][CCI_CLDATA_W-1:0] req_data;
  logic c1_almost_full, wr_rsp_valid, drain_req;

  logic [N-1:0]           a_stall, b_stall;
  logic                   a_wr_valid, b_wr_valid;
  logic [CCI_CLADDR_W-1:0] a_wr_addr, b_wr_addr;
  logic [CCI_CLDATA_W-1:0] a_wr_data, b_wr_data;
  logic                   a_done, b_done, a_err, b_err;
  logic [6:0]             a_out;
  logic [2:0]             b_out;
  logic [N-1:0][31:0]     a_stat, b_stat;

  write_arbiter #(.N_REQ(N), .MAX_OUTSTANDING(64)) u_dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_stall(a_stall), .c1_almost_full(c1_almost_full),
    .wr_valid(a_wr_valid), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .wr_rsp_valid(wr_rsp_valid), .drain_req(drain_req), .drain_done(a_done),
    .outstanding(a_out), .err_underflow(a_err), .stat_issued(a_stat));

  write_arbiter #(.N_REQ(N), .MAX_OUTSTANDING(4)) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_stall(b_stall), .c1_almost_full(c1_almost_full),
    .wr_valid(b_wr_valid), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_rsp_valid(wr_rsp_valid), .drain_req(drain_req), .drain_done(b_done),
    .outstanding(b_out), .err_underflow(b_err), .stat_issued(b_stat));

  int n_vec = 0, n_err = 0;
  logic [N-1:0] want, h1, h2, h3;
  logic         model;
  int           seq [N];
  logic [CCI_CLADDR_W-1:0] sbq [N][$];
  int           last_id, wcnt_a, wcnt_b;

  function automatic logic [CCI_CLADDR_W-1:0] mk_addr(input int id, input int s);
    return (CCI_CLADDR_W'(id) << 16) | CCI_CLADDR_W'(s & 16'hFFFF);
  endfunction

  function automatic logic [CCI_CLDATA_W-1:0] mk_data(input logic [CCI_CLADDR_W-1:0] a);
    return {8{22'h0, a}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive requester valids (model = honour stall with 2-cycle
  // latency), record pushes, then check any write on DUT A against the
  // per-requester scoreboard.
  task automatic tick();
    int id;
    logic [CCI_CLADDR_W-1:0] exp_a;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = want[i] & (~model | ~h3[i]);
      req_addr[i]  = mk_addr(i, seq[i]);
      req_data[i]  = mk_data(req_addr[i]);
    end
    @(posedge clk);
    if (!reset)
      for (int i = 0; i < N; i++)
        if (req_valid[i]) begin sbq[i].push_back(req_addr[i]); seq[i]++; end
    #1;
    h3 = h2; h2 = h1; h1 = a_stall;
    if (a_wr_valid) begin
      id = int'(a_wr_addr[19:16]);
      last_id = id;
      wcnt_a++;
      exp_a = '1;
      if (id < N && sbq[id].size() != 0) exp_a = sbq[id].pop_front();
      chk("sb_addr", 64'(a_wr_addr), 64'(exp_a));
      n_vec++;
      assert (a_wr_data === mk_data(exp_a)) else begin
        n_err++;
        $error("FAIL sb_data observed=%0h expected=%0h", a_wr_data[63:0], mk_data(exp_a) >> 0);
      end
    end
    if (b_wr_valid) wcnt_b++;
  endtask

  task automatic do_reset();
    reset = 1'b1; want = '0; model = 1'b0; drain_req = 1'b0;
    wr_rsp_valid = 1'b0; c1_almost_full = 1'b0;
    h1 = '0; h2 = '0; h3 = '0;
    for (int i = 0; i < N; i++) begin seq[i] = 0; sbq[i].delete(); end
    tick(); tick();
    reset = 1'b0; wcnt_a = 0; wcnt_b = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    req_valid = '0; req_addr = '0; req_data = '0;
    want = '0; model = 1'b0; last_id = -1;

    // Reset state
    do_reset();
    chk("rst_wr_valid", 64'(a_wr_valid), 64'd0);
    chk("rst_wr_addr",  64'(a_wr_addr),  64'd0);
    chk("rst_wr_data",  64'(a_wr_data[63:0]), 64'd0);
    chk("rst_out",      64'(a_out),      64'd0);
    chk("rst_stall",    64'(a_stall),    64'd0);
    chk("rst_done",     64'(a_done),     64'd0);
    chk("rst_err",      64'(a_err),      64'd0);

    // Four requesters streaming: grants 0,1,2,3,0,.. one per cycle
    model = 1'b1; want = 4'hF;
    tick();
    chk("rr_first_idle", 64'(a_wr_valid), 64'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_valid", 64'(a_wr_valid), 64'd1);
      chk("rr_grant", 64'(last_id), 64'(k % 4));
      chk("rr_out",   64'(a_out), 64'(k + 1));
    end
    want = '0;
    for (int k = 0; k < 20; k++) tick();
    chk("rr_all_issued", 64'(wcnt_a), 64'(seq[0] + seq[1] + seq[2] + seq[3]));

    // Almost-full backpressure with requester 0 streaming
    do_reset();
    model = 1'b1; want = 4'b0001; c1_almost_full = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      chk("af_no_write", 64'(a_wr_valid), 64'd0);
      if (t == 2) chk("af_stall0", 64'(a_stall[0]), 64'd1);
    end
    c1_almost_full = 1'b0;
    for (int t = 0; t < 12; t++) tick();
    want = '0;
    for (int t = 0; t < 10; t++) tick();
    chk("af_count", 64'(wcnt_a), 64'(seq[0]));
    chk("af_sb_empty", 64'(sbq[0].size()), 64'd0);

    // Credit limit on the MAX_OUTSTANDING=4 instance
    do_reset();
    want = 4'b0001;
    for (int t = 0; t < 6; t++) tick();
    want = '0;
    for (int t = 0; t < 6; t++) tick();
    chk("cred_writes", 64'(wcnt_b), 64'd4);
    chk("cred_out",    64'(b_out),  64'd4);
    wcnt_b = 0;
    wr_rsp_valid = 1'b1; tick(); wr_rsp_valid = 1'b0;
    for (int t = 0; t < 6; t++) tick();
    chk("cred_one_more", 64'(wcnt_b), 64'd1);
    chk("cred_out2",     64'(b_out),  64'd4);

    // Simultaneous issue+response at 3, then underflow
    do_reset();
    want = 4'b0001;
    for (int t = 0; t < 4; t++) tick();
    want = '0;
    chk("sim_pre3", 64'(a_out), 64'd3);
    wr_rsp_valid = 1'b1;
    tick();
    chk("sim_hold3",  64'(a_out), 64'd3);
    chk("sim_issued", 64'(a_wr_valid), 64'd1);
    tick(); tick(); tick();
    chk("uf_at0",   64'(a_out), 64'd0);
    chk("uf_noerr", 64'(a_err), 64'd0);
    tick();
    chk("uf_out", 64'(a_out), 64'd0);
    chk("uf_err", 64'(a_err), 64'd1);
    wr_rsp_valid = 1'b0;
    tick(); tick();
    chk("uf_sticky", 64'(a_err), 64'd1);

    // Drain with 3 queued writes and 2 outstanding
    do_reset();
    want = 4'b0001;
    tick(); tick();
    want = '0;
    tick();
    chk("dr_out2", 64'(a_out), 64'd2);
    c1_almost_full = 1'b1; want = 4'b0010;
    tick(); tick(); tick();
    want = '0; c1_almost_full = 1'b0; drain_req = 1'b1; wcnt_a = 0;
    tick();
    chk("dr_stall_all", 64'(a_stall), 64'hF);
    for (int t = 0; t < 7; t++) tick();
    chk("dr_writes", 64'(wcnt_a), 64'd3);
    chk("dr_out5",   64'(a_out),  64'd5);
    wr_rsp_valid = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    chk("dr_not_done", 64'(a_done), 64'd0);
    tick();
    wr_rsp_valid = 1'b0;
    chk("dr_out0", 64'(a_out), 64'd0);
    for (int t = 0; t < 5 && !a_done; t++) tick();
    chk("dr_done", 64'(a_done), 64'd1);
    drain_req = 1'b0;
    tick();
    chk("dr_run_done", 64'(a_done), 64'd0);
    chk("dr_run_stall", 64'(a_stall), 64'd0);

    // Reset mid-operation with FIFOs partly full
    do_reset();
    model = 1'b1; want = 4'hF;
    tick(); tick(); tick();
    c1_almost_full = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1; want = '0; model = 1'b0; h1 = '0; h2 = '0; h3 = '0;
    for (int i = 0; i < N; i++) begin seq[i] = 0; sbq[i].delete(); end
    tick();
    chk("mr_wr_valid", 64'(a_wr_valid), 64'd0);
    chk("mr_out",      64'(a_out),      64'd0);
    chk("mr_stall",    64'(a_stall),    64'd0);
    reset = 1'b0; c1_almost_full = 1'b0;
    tick();
    chk("mr_no_write", 64'(a_wr_valid), 64'd0);
    want = 4'hF;
    tick();
    want = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mr_valid", 64'(a_wr_valid), 64'd1);
      chk("mr_rr0",   64'(last_id),    64'(k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/write_arbiter.md
WRITE_ARBITER -- requirements
Module: write_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of write requesters, range 2..8.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 64, meaning the write-credit limit.
REQ-003 SHALL have port clk, in, 1, clock.
REQ-004 SHALL have port reset, in, 1, synchronous, active-high.
REQ-005 SHALL have port req_valid, in, N_REQ, per-requester write valid.
REQ-006 SHALL have port req_addr, in, N_REQ x t_cci_clAddr, per-requester line address.
REQ-007 SHALL have port req_data, in, N_REQ x t_cci_clData, per-requester line data.
REQ-008 SHALL have port req_stall, out, N_REQ, per-requester backpressure.
REQ-009 SHALL have port c1_almost_full, in, 1, CCI write channel almost-full.
REQ-010 SHALL have port wr_valid / wr_addr / wr_data, out, 1 / t_cci_clAddr / t_cci_clData, merged write request.
REQ-011 SHALL have port wr_rsp_valid, in, 1, one write completion.
REQ-012 SHALL have port drain_req, in, 1, quiesce request.
REQ-013 SHALL have port drain_done, out, 1, quiesced.
REQ-014 SHALL have port outstanding, out, clog2(MAX_OUTSTANDING+1), in-flight writes.
REQ-015 SHALL have port err_underflow, out, 1, sticky response-without-request flag.

Function
REQ-016 SHALL give each requester a 4-entry skid FIFO that accepts a write on every cycle req_valid[i]=1.
REQ-017 SHALL assert req_stall[i] while FIFO i occupancy >= 2, covering the requester's 2-cycle stall-to-valid latency; FIFO overflow is never permitted.
REQ-018 SHALL make an issue cycle (all three true):
- any FIFO non-empty
- c1_almost_full=0
- outstanding < MAX_OUTSTANDING
REQ-019 SHALL grant round-robin, starting the search at rr_ptr; after a grant to i, rr_ptr = (i+1) mod N_REQ; rr_ptr is held on non-issue cycles.
REQ-020 SHALL pop the granted FIFO head and present it on wr_valid/wr_addr/wr_data one cycle later (registered output); wr_valid=0 on non-issue cycles.
REQ-021 SHALL update outstanding as:
- +1 per issue
- -1 per wr_rsp_valid
- unchanged when both occur in one cycle
REQ-022 SHALL hold outstanding at 0 and set err_underflow on wr_rsp_valid with outstanding=0 and no concurrent issue; err_underflow clears only on reset.
REQ-023 SHALL implement an FSM with states RUN, DRAIN, DONE:
- RUN->DRAIN on drain_req=1.
- In DRAIN: all req_stall=1; FIFOs continue issuing.
- DRAIN->DONE when all FIFOs are empty, outstanding=0 and no write is pending in the output register.
- DONE->RUN on drain_req=0.
REQ-024 SHALL assert drain_done only in DONE.
REQ-025 SHALL still accept requester valids arriving in DRAIN that were already in flight; they are issued before DONE.

Reset
REQ-026 SHALL apply the following on reset:
- FSM=RUN, rr_ptr=0, FIFOs empty, outstanding=0.
- wr_valid=0, wr_addr=0, wr_data=0.
- req_stall all 0, drain_done=0, err_underflow=0.
REQ-027 SHALL discard FIFO contents and in-flight writes on a reset mid-operation; no wr_valid in the cycle after reset.

Configuration
REQ-028 SHALL, with WRITE_ARBITER_STATS_EN defined, keep per-requester 32-bit issue counters (wrapping, reset 0), exposed on output stat_issued (N_REQ x 32).
REQ-029 SHALL, without WRITE_ARBITER_STATS_EN, drive stat_issued to constant 0 and synthesize no counters.

Structure
REQ-030 SHALL place t_arb_state (RUN/DRAIN/DONE), WR_SKID_DEPTH=4 and WR_STALL_THRESH=2 in package afu_base.
REQ-031 SHALL implement the skid FIFO as sub-module write_skid_fifo (push, pop, addr+data, occupancy), instantiated N_REQ times.

Verification
REQ-032 SHALL cover: all 4 requesters with req_valid=1 continuously -> grants 0,1,2,3,0,... one per cycle; outstanding increments by 1 per cycle.
REQ-033 SHALL cover: c1_almost_full=1 for 10 cycles with requester 0 streaming -> req_stall[0] within 2 cycles, no wr_valid, no FIFO overflow, no lost or duplicated address.
REQ-034 SHALL cover: MAX_OUTSTANDING=4 with no responses -> exactly 4 writes, then stall; one wr_rsp_valid -> exactly one more write.
REQ-035 SHALL cover: issue and wr_rsp_valid in the same cycle at outstanding=3 -> stays 3; wr_rsp_valid at 0 -> err_underflow=1, outstanding=0.
REQ-036 SHALL cover: drain_req with 3 queued writes and 2 outstanding -> 3 writes issued, then after 5 responses drain_done=1; drain_req=0 -> RUN.
REQ-037 SHALL cover: reset asserted with FIFOs half full -> next cycle wr_valid=0, outstanding=0, rr_ptr=0.
